// File: rtl/silife_max7219.sv
// silife_max7219: pushes an 8x8 Game-of-Life grid to a MAX7219 LED-matrix
// controller. After reset it sends the 5-word init sequence by itself. Each
// frame request then sends the 8 row registers followed by the intensity word.
// Each word is 16 bits, sent MSB first, with CS low for the whole word.
module silife_max7219 #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] i_cells,
    input  logic        i_frame,
    input  logic [3:0]  i_intensity,
    output logic        o_busy,
    output logic        o_cs,
    output logic        o_sck,
    output logic        o_mosi
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_FRAME} state_t;
    typedef enum logic [1:0] {P_LOAD, P_SHIFT, P_GAP} phase_t;

    localparam logic [8:0] HALF_END = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_END  = 9'(2 * CLK_DIV - 1);

    state_t      r_state;
    phase_t      r_phase;
    logic [3:0]  r_word;
    logic [3:0]  r_bit;
    logic [8:0]  r_div;
    logic [14:0] r_shift;
    logic [63:0] r_cells;
    logic        r_pend;
    logic        r_cs, r_sck, r_mosi, r_busy;

    logic        w_last, w_start;
    state_t      w_ld_state;
    logic [3:0]  w_ld_idx;
    logic [63:0] w_ld_cells;
    logic [15:0] w_ld_word;

    // Word idx of the init or frame sequence. Row r is cells[8r+7:8r] and goes to address r+1.
    function automatic logic [15:0] f_word(state_t st, logic [3:0] idx,
                                           logic [63:0] cells, logic [3:0] inten);
        logic [15:0] w;
        w = {8'h0A, 4'h0, inten};
        if (st == S_INIT) begin
            case (idx)
                4'd0:    w = 16'h0C01;
                4'd1:    w = 16'h0B07;
                4'd2:    w = 16'h0900;
                4'd3:    w = {8'h0A, 4'h0, inten};
                default: w = 16'h0F00;
            endcase
        end else if (idx < 4'd8) begin
            w = {4'h0, idx + 4'd1, cells[{idx[2:0], 3'b000} +: 8]};
        end
        return w;
    endfunction

    // Select the next word to load. At the end of a sequence, a pending or
    // arriving request starts a new frame at once, with no idle cycle between frames.
    always_comb begin
        w_last     = (r_state == S_INIT) ? (r_word == 4'd4) : (r_word == 4'd8);
        w_start    = w_last && (r_pend || i_frame);
        w_ld_state = r_state;
        w_ld_idx   = r_word;
        w_ld_cells = r_cells;
        if (r_phase == P_GAP) begin
            if (w_start) begin
                w_ld_state = S_FRAME;
                w_ld_idx   = 4'd0;
                w_ld_cells = i_cells;
            end else begin
                w_ld_idx = r_word + 4'd1;
            end
        end
        w_ld_word = f_word(w_ld_state, w_ld_idx, w_ld_cells, i_intensity);
    end

    // Sequence and word FSM, serial shifter and registered SPI outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_INIT;
            r_phase <= P_LOAD;
            r_word  <= 4'd0;
            r_bit   <= 4'hF;
            r_div   <= 9'd0;
            r_shift <= 15'd0;
            r_cells <= 64'd0;
            r_pend  <= 1'b0;
            r_cs    <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            // Pending flag holds one request. Extra requests are dropped.
            // A frame start clears the flag; the assignment below wins.
            if (i_frame && r_state != S_IDLE)
                r_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (i_frame) begin
                        r_state <= S_FRAME;
                        r_phase <= P_LOAD;
                        r_word  <= 4'd0;
                        r_cells <= i_cells;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    case (r_phase)
                        P_LOAD: begin
                            r_shift <= w_ld_word[14:0];
                            r_mosi  <= w_ld_word[15];
                            r_cs    <= 1'b0;
                            r_sck   <= 1'b0;
                            r_div   <= 9'd0;
                            r_bit   <= 4'hF;
                            r_phase <= P_SHIFT;
                        end
                        P_SHIFT: begin
                            if (r_div == HALF_END) begin
                                r_div <= 9'd0;
                                if (!r_sck) begin
                                    r_sck <= 1'b1;
                                end else begin
                                    r_sck <= 1'b0;
                                    if (r_bit == 4'd0) begin
                                        r_cs    <= 1'b1;
                                        r_mosi  <= 1'b0;
                                        r_phase <= P_GAP;
                                    end else begin
                                        r_bit   <= r_bit - 4'd1;
                                        r_mosi  <= r_shift[14];
                                        r_shift <= {r_shift[13:0], 1'b0};
                                    end
                                end
                            end else begin
                                r_div <= r_div + 9'd1;
                            end
                        end
                        default: begin
                            if (r_div == GAP_END) begin
                                r_div <= 9'd0;
                                if (w_last && !w_start) begin
                                    r_state <= S_IDLE;
                                    r_phase <= P_LOAD;
                                    r_busy  <= 1'b0;
                                end else begin
                                    r_state <= w_ld_state;
                                    r_word  <= w_ld_idx;
                                    r_shift <= w_ld_word[14:0];
                                    r_mosi  <= w_ld_word[15];
                                    r_cs    <= 1'b0;
                                    r_bit   <= 4'hF;
                                    r_phase <= P_SHIFT;
                                    if (w_start) begin
                                        r_cells <= i_cells;
                                        r_pend  <= 1'b0;
                                    end
                                end
                            end else begin
                                r_div <= r_div + 9'd1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_cs   = r_cs;
    assign o_sck  = r_sck;
    assign o_mosi = r_mosi;

endmodule

// File: doc/silife_max7219.md
# silife_max7219

Downstream display stage for the silife Game-of-Life core. It takes an 8×8 cell grid snapshot and drives a MAX7219 LED-matrix controller over a 3-wire SPI-style link (CS, SCK, MOSI). After reset it autonomously sends the controller initialisation sequence. Then, on each frame strobe, it sends the 8 row registers plus the intensity register.

## Interface
Parameters:
- CLK_DIV, 2: SCK half-period in clk cycles; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- i_cells  input  64  grid state; row r (0..7) is i_cells[8r+7:8r]; bit 8r+7 maps to column 0 (the MSB sent).
- i_frame  input  1  single-cycle request to refresh the display.
- i_intensity  input  4  MAX7219 intensity value, sent in every frame.
- o_busy  output  1  high while initialising, transmitting, or holding a pending frame.
- o_cs  output  1  chip select, active-low.
- o_sck  output  1  serial clock, idles low; slave samples on the rising edge.
- o_mosi  output  1  serial data, MSB first.

## Operation
- Each transfer is one 16-bit word: {4'h0, addr[3:0], data[7:0]}, sent MSB first.
- States:
  - INIT: sends 5 words. Leaves to IDLE after the 5th word's CS-high gap.
  - IDLE: waits for a frame request.
  - FRAME: sends 9 words. Returns to IDLE when done, or starts another FRAME if a request is pending.
  - Word-level sub-states: SHIFT (CS low, 16 bits) and GAP (CS high).
- INIT sequence:
  - 16'h0C01 (normal operation)
  - 16'h0B07 (scan limit 7)
  - 16'h0900 (no decode)
  - {8'h0A, 4'h0, i_intensity}
  - 16'h0F00 (display test off)
- FRAME sequence:
  - Rows: addr 1..8, with data for addr r+1 = snapshot[8r+7:8r].
  - Then intensity word {8'h0A, 4'h0, i_intensity}.
- Snapshots:
  - The cell snapshot is registered in the cycle FRAME begins.
  - i_intensity is sampled when its own word is loaded.
- Frame requests:
  - A request in IDLE is accepted immediately.
  - A request during INIT or FRAME sets a 1-deep pending flag. Further requests while the flag is set are dropped.
  - The pending flag clears when its FRAME begins.
- Word-counter and bit-counter wrap are internal only; no partial words are ever emitted except when cut by reset.

## Timing
- Reset values: o_cs=1, o_sck=0, o_mosi=0, o_busy=1; state INIT at word 0, pending=0.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronously); INIT restarts after release.
- INIT start: the first word's CS falls on the first clk edge after reset releases.
- Frame start: i_frame accepted in IDLE at edge N gives o_cs=0 and o_busy=1 after edge N+1.
- Word timing, with t0 = cycle CS falls:
  - o_mosi = bit15 at t0; o_sck rises at t0+CLK_DIV and falls at t0+2·CLK_DIV.
  - At each SCK fall, o_mosi advances to the next bit, so MOSI is stable for CLK_DIV cycles around each rising edge.
  - After bit0's high phase: at t0+32·CLK_DIV, o_sck=0, o_cs=1, o_mosi=0.
  - CS stays high for 2·CLK_DIV cycles; the next word's CS falls at t0+34·CLK_DIV.
- Word = 34·CLK_DIV cycles; INIT = 170·CLK_DIV; FRAME = 306·CLK_DIV.
- o_busy falls in the same cycle the state enters IDLE with pending=0.
- i_frame arriving in the final GAP cycle is treated as pending, giving back-to-back frames with no extra idle cycle.

## Test plan
All with CLK_DIV=2.
- Reset release → decoded words 0C01, 0B07, 0900, 0A0<i_intensity>, 0F00; CS rises 5 times; o_busy low after 340 cycles; no SCK edges while CS is high.
- IDLE, i_cells=64'h8000_0000_0000_0001, i_intensity=4'h7, pulse i_frame → words 0101, 0200, 0300, 0400, 0500, 0600, 0700, 0880, 0A07; CS low 1 cycle after accept.
- i_frame pulsed twice during one FRAME → exactly one extra FRAME follows; its snapshot reflects i_cells at that FRAME's start; o_busy stays high throughout.
- Change i_cells during a FRAME → transmitted rows match the value captured at that FRAME's start.
- Assert reset mid-word → o_cs=1, o_sck=0, o_mosi=0 without a clock edge; after release, the full INIT sequence repeats from 0C01.
- Per-bit timing check → MOSI stable ≥2 cycles before and after each SCK rise; 16 rises per CS-low window; 4-cycle CS-high gap.
